// File: rtl/id_pkg.sv
// Shared decode-stage definitions: branch types, in_ctrl layout, extend modes.
package id_pkg;

  localparam int unsigned CTRL_W = 7;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;
  localparam logic [2:0] BR_RSVD = 3'd7;

  localparam int unsigned CTRL_EXSIGN  = 0;
  localparam int unsigned CTRL_EXTOP   = 1;
  localparam int unsigned CTRL_BT_LSB  = 2;
  localparam int unsigned CTRL_NPC_GPR = 5;
  localparam int unsigned CTRL_JMP     = 6;

  localparam logic [1:0] EXT_NONE = 2'd0;
  localparam logic [1:0] EXT_ZERO = 2'd1;
  localparam logic [1:0] EXT_SIGN = 2'd2;

  typedef struct packed {
    logic       jmp;
    logic       npc_from_gpr;
    logic [2:0] branch_type;
    logic       extop;
    logic       exsign;
  } id_ctrl_t;

  function automatic logic [1:0] ext_mode(input logic extop, input logic exsign);
    if (!extop) return EXT_NONE;
    return exsign ? EXT_SIGN : EXT_ZERO;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// GPR file: two combinational read ports, one write port, write-to-read bypass.
module id_regfile #(
  parameter  int unsigned XLEN = 32,
  parameter  int unsigned NREG = 32,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  // A write landing this cycle is visible to the reader immediately.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (wr_en && wa == ra1) rd1 = wd;
    if (wr_en && wa == ra2) rd2 = wd;
    if (ra1 == '0) rd1 = '0;
    if (ra2 == '0) rd2 = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: forwarded register read, immediate, load-use stall, ID/EX register.
// Optional early branch/jump resolution in ID under `define ID_EARLY_BRANCH_EN.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREG   = 32,
  parameter  int unsigned NFWD   = 2,
  parameter  int unsigned PASS_W = 20,
  localparam int unsigned RA_W   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PASS_W-1:0]    in_pass,
  input  logic                 wb_we,
  input  logic [RA_W-1:0]      wb_rw,
  input  logic [XLEN-1:0]      wb_wd,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*RA_W-1:0] fwd_rw,
  input  logic [NFWD*XLEN-1:0] fwd_wd,
  input  logic                 hz_load,
  input  logic [RA_W-1:0]      hz_rw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_rd1,
  output logic [XLEN-1:0]      out_rd2,
  output logic [XLEN-1:0]      out_imm,
  output logic [PASS_W-1:0]    out_pass,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc
);

  id_ctrl_t        ctrl;
  logic [RA_W-1:0] rs, rt;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] opa, opb;
  logic [XLEN-1:0] imm;
  logic            hazard;
  logic            accept;

  assign ctrl = id_ctrl_t'(in_ctrl);
  assign rs   = in_instr[21 +: RA_W];
  assign rt   = in_instr[16 +: RA_W];

  id_regfile #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_we),
    .wa  (wb_rw),
    .wd  (wb_wd)
  );

  // Walk oldest to youngest so the lowest matching index wins; WB bypass lives in the regfile.
  always_comb begin
    opa = rf_rd1;
    opb = rf_rd2;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rw[i*RA_W +: RA_W] == rs) opa = fwd_wd[i*XLEN +: XLEN];
      if (fwd_valid[i] && fwd_rw[i*RA_W +: RA_W] == rt) opb = fwd_wd[i*XLEN +: XLEN];
    end
    if (rs == '0) opa = '0;
    if (rt == '0) opb = '0;
  end

  always_comb begin
    imm = '0;
    unique case (ext_mode(ctrl.extop, ctrl.exsign))
      EXT_SIGN: imm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
      EXT_ZERO: imm = {{(XLEN-16){1'b0}}, in_instr[15:0]};
      default:  imm = '0;
    endcase
  end

  assign hazard   = hz_load && (hz_rw != '0) && (hz_rw == rs || hz_rw == rt);
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ID_EARLY_BRANCH_EN
  logic        taken;
  logic [31:0] pc_plus4, br_target, j_target;

  assign pc_plus4  = in_pc + 32'd4;
  assign br_target = pc_plus4 + {{14{in_instr[15]}}, in_instr[15:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], in_instr[25:0], 2'b00};

  always_comb begin
    taken = 1'b0;
    unique case (ctrl.branch_type)
      BR_BEQ:  taken = (opa == opb);
      BR_BNE:  taken = (opa != opb);
      BR_BLEZ: taken = opa[XLEN-1] || (opa == '0);
      BR_BGTZ: taken = !opa[XLEN-1] && (opa != '0);
      BR_BLTZ: taken = opa[XLEN-1];
      BR_BGEZ: taken = !opa[XLEN-1];
      default: taken = 1'b0;
    endcase
  end

  assign redirect_valid = accept && (ctrl.jmp || ctrl.npc_from_gpr || taken);
  assign redirect_pc    = ctrl.npc_from_gpr ? opa[31:0] :
                          ctrl.jmp          ? j_target  : br_target;
`else
  logic unused_ctrl;

  // Control flow is resolved in EX from out_instr/out_pass in this build.
  assign unused_ctrl    = ^{ctrl.jmp, ctrl.npc_from_gpr, ctrl.branch_type};
  assign redirect_valid = 1'b0;
  assign redirect_pc    = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      out_rd1   <= '0;
      out_rd2   <= '0;
      out_imm   <= '0;
      out_pass  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_rd1   <= opa;
      out_rd2   <= opb;
      out_imm   <= imm;
      out_pass  <= in_pass;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: vector table plus stall/flush/reset sequences.
module tb_id_stage_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NFWD   = 2;
  localparam int unsigned PASS_W = 20;
  localparam int unsigned RA_W   = 5;

  logic                 clk, rst, flush, in_valid, in_ready;
  logic [31:0]          in_pc, in_instr;
  logic [6:0]           in_ctrl;
  logic [PASS_W-1:0]    in_pass;
  logic                 wb_we;
  logic [RA_W-1:0]      wb_rw;
  logic [XLEN-1:0]      wb_wd;
  logic [NFWD-1:0]      fwd_valid;
  logic [NFWD*RA_W-1:0] fwd_rw;
  logic [NFWD*XLEN-1:0] fwd_wd;
  logic                 hz_load;
  logic [RA_W-1:0]      hz_rw;
  logic                 out_valid, out_ready;
  logic [31:0]          out_pc, out_instr;
  logic [XLEN-1:0]      out_rd1, out_rd2, out_imm;
  logic [PASS_W-1:0]    out_pass;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;

  id_stage_pipe #(
    .XLEN(XLEN), .NREG(NREG), .NFWD(NFWD), .PASS_W(PASS_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl), .in_pass(in_pass),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_wd(wb_wd),
    .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_wd(fwd_wd),
    .hz_load(hz_load), .hz_rw(hz_rw),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_pass(out_pass),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [15:0] imm16);
    return {6'd0, rs, rt, imm16};
  endfunction

  function automatic logic [6:0] mkc(input logic j, input logic g, input logic [2:0] bt,
                                     input logic eo, input logic es);
    return {j, g, bt, eo, es};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    wb_we     = 1'b0;
    fwd_valid = '0;
    hz_load   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_we = 1'b1; wb_rw = r; wb_wd = d;
    tick();
    wb_we = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  ctrl;
    logic [1:0]  fv;
    logic [4:0]  f0rw, f1rw;
    logic [31:0] f0wd, f1wd;
    logic        we;
    logic [4:0]  wrw;
    logic [31:0] wwd;
    logic [31:0] e1, e2, eimm;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic [31:0] held_instr;

  initial begin
    vecs[0] = '{mk(5, 0, 16'h8000), mkc(0,0,3'd0,1,1), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                1'b0, 5'd0, 32'h0, 32'h1234, 32'h0, 32'hFFFF8000};
    vecs[1] = '{mk(3, 3, 16'h1234), mkc(0,0,3'd0,0,0), 2'b11, 5'd3, 5'd3, 32'hAAAA, 32'hBBBB,
                1'b1, 5'd3, 32'hCCCC, 32'hAAAA, 32'hAAAA, 32'h0};
    vecs[2] = '{mk(3, 0, 16'h1234), mkc(0,0,3'd0,0,0), 2'b10, 5'd3, 5'd3, 32'hAAAA, 32'hBBBB,
                1'b1, 5'd3, 32'hCCCC, 32'hBBBB, 32'h0, 32'h0};
    vecs[3] = '{mk(3, 0, 16'hABCD), mkc(0,0,3'd0,1,0), 2'b00, 5'd3, 5'd3, 32'hAAAA, 32'hBBBB,
                1'b1, 5'd3, 32'hCCCC, 32'hCCCC, 32'h0, 32'h0000ABCD};
    vecs[4] = '{mk(3, 5, 16'hABCD), mkc(0,0,3'd0,1,1), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                1'b1, 5'd3, 32'hDDDD, 32'hDDDD, 32'h1234, 32'hFFFFABCD};
    vecs[5] = '{mk(0, 0, 16'h5555), mkc(0,0,3'd0,0,0), 2'b11, 5'd0, 5'd0, 32'hAAAA, 32'hBBBB,
                1'b1, 5'd0, 32'hCCCC, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{mk(0, 3, 16'h8000), mkc(0,0,3'd0,1,0), 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                1'b0, 5'd0, 32'h0, 32'h0, 32'hDDDD, 32'h00008000};
    vecs[7] = '{mk(1, 2, 16'h7FFF), mkc(0,0,3'd0,1,1), 2'b10, 5'd0, 5'd2, 32'h0, 32'h77,
                1'b0, 5'd0, 32'h0, 32'h9, 32'h77, 32'h00007FFF};

    // Reset state
    rst = 1'b0; idle();
    in_pc = '0; in_instr = '0; in_ctrl = '0; in_pass = '0;
    wb_rw = '0; wb_wd = '0; fwd_rw = '0; fwd_wd = '0; hz_rw = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_rd1", out_rd1, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    chk("rst_out_pass", 32'(out_pass), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    wb_write(5'd5, 32'h1234);
    wb_write(5'd1, 32'h9);
    wb_write(5'd2, 32'h9);

    // Vector table: back-to-back accepts with out_ready held high
    for (int i = 0; i < NV; i++) begin
      in_valid  = 1'b1;
      in_pc     = 32'h1000 + 32'(i) * 32'd4;
      in_instr  = vecs[i].instr;
      in_ctrl   = vecs[i].ctrl;
      in_pass   = PASS_W'(i + 16);
      fwd_valid = vecs[i].fv;
      fwd_rw    = {vecs[i].f1rw, vecs[i].f0rw};
      fwd_wd    = {vecs[i].f1wd, vecs[i].f0wd};
      wb_we     = vecs[i].we;
      wb_rw     = vecs[i].wrw;
      wb_wd     = vecs[i].wwd;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_redirect", i), 32'(redirect_valid), 32'd0);
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_rd1", i), out_rd1, vecs[i].e1);
      chk($sformatf("v%0d_rd2", i), out_rd2, vecs[i].e2);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].eimm);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i) * 32'd4);
      chk($sformatf("v%0d_pass", i), 32'(out_pass), 32'(i + 16));
    end
    idle();

    // Load-use hazard on rt; hazard on r0 never stalls
    in_valid = 1'b1; in_instr = mk(1, 7, 16'h0); in_ctrl = '0; in_pc = 32'h2000;
    hz_load = 1'b1; hz_rw = 5'd0;
    in_instr = mk(0, 0, 16'h0);
    #1;
    chk("hz_r0_in_ready", 32'(in_ready), 32'd1);
    in_instr = mk(1, 7, 16'h0); hz_rw = 5'd7;
    #1;
    chk("hz_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("hz_bubble", 32'(out_valid), 32'd0);
    hz_load = 1'b0;
    #1;
    chk("hz_clear_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("hz_accept_valid", 32'(out_valid), 32'd1);
    chk("hz_accept_instr", out_instr, mk(1, 7, 16'h0));
    chk("hz_accept_rd1", out_rd1, 32'h9);

    // Back-pressure for 3 cycles, then handshake plus accept in one edge
    held_instr = mk(1, 7, 16'h0);
    out_ready = 1'b0; in_instr = mk(5, 1, 16'h0042); in_pc = 32'h2004;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_instr", k), out_instr, held_instr);
      chk($sformatf("bp%0d_pc", k), out_pc, 32'h2000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_rel_valid", 32'(out_valid), 32'd1);
    chk("bp_rel_instr", out_instr, mk(5, 1, 16'h0042));
    chk("bp_rel_rd1", out_rd1, 32'h1234);
    chk("bp_rel_rd2", out_rd2, 32'h9);

    // Early branch/jump resolution
    in_valid = 1'b1; in_pc = 32'h100; in_instr = mk(1, 2, 16'h0004);
    in_ctrl = mkc(0, 0, 3'd1, 1, 1);
`ifdef ID_EARLY_BRANCH_EN
    #1;
    chk("beq_taken", 32'(redirect_valid), 32'd1);
    chk("beq_target", redirect_pc, 32'h114);
    tick();
    fwd_valid = 2'b10; fwd_rw = {5'd2, 5'd0}; fwd_wd = {32'h8, 32'h0};
    #1;
    chk("beq_not_taken", 32'(redirect_valid), 32'd0);
    tick();
    in_instr = mk(31, 0, 16'h0); in_ctrl = mkc(0, 1, 3'd0, 0, 0);
    fwd_valid = 2'b01; fwd_rw = {5'd0, 5'd31}; fwd_wd = {32'h0, 32'h400};
    #1;
    chk("jr_valid", 32'(redirect_valid), 32'd1);
    chk("jr_target", redirect_pc, 32'h400);
    tick();
    fwd_valid = '0;
    in_instr = {6'h02, 26'h0123456}; in_ctrl = mkc(1, 0, 3'd0, 0, 0);
    #1;
    chk("j_valid", 32'(redirect_valid), 32'd1);
    chk("j_target", redirect_pc, 32'h048D158);
    tick();
    in_pc = 32'h200; in_instr = mk(1, 0, 16'hFFFF); in_ctrl = mkc(0, 0, 3'd5, 1, 1);
    fwd_valid = 2'b01; fwd_rw = {5'd0, 5'd1}; fwd_wd = {32'h0, 32'hFFFFFFFF};
    #1;
    chk("bltz_valid", 32'(redirect_valid), 32'd1);
    chk("bltz_target", redirect_pc, 32'h200);
    tick();
    fwd_valid = '0; in_ctrl = mkc(0, 0, 3'd3, 1, 1);
    #1;
    chk("blez_pos_not_taken", 32'(redirect_valid), 32'd0);
    tick();
`else
    #1;
    chk("beq_no_redirect", 32'(redirect_valid), 32'd0);
    chk("beq_no_redirect_pc", redirect_pc, 32'd0);
    tick();
`endif
    idle();

    // Flush with a taken branch presented
    in_valid = 1'b1; flush = 1'b1; in_pc = 32'h100; in_instr = mk(1, 2, 16'h0004);
    in_ctrl = mkc(0, 0, 3'd1, 1, 1);
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_redirect", 32'(redirect_valid), 32'd0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    idle();

    // Asynchronous reset in the middle of a stall
    in_valid = 1'b1; in_instr = mk(5, 0, 16'h0); in_ctrl = '0; in_pc = 32'h300;
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    tick();
    chk("stall_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("post_rst_accept", 32'(out_valid), 32'd1);
    chk("post_rst_rf_clear", out_rd1, 32'd0);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the MIPS pipeline: register read with multi-source forwarding, immediate extension, optional early branch/jump resolution, and an ID/EX pipeline register with valid/ready handshake. Replaces the fixed-width, always-advancing decode stage. Adds load-use stall detection and back-pressure so EX can hold the stage. Sits between the IF/ID register and EX.

## Interface
- `XLEN`, 32: GPR data width (≥32).
- `NREG`, 32: register count, power of 2; `RA_W = $clog2(NREG)`; instruction fields rs/rt use low `RA_W` bits of [25:21]/[20:16].
- `NFWD`, 2: forwarding sources; index 0 is youngest.
- `PASS_W`, 20: width of opaque EX/MEM/WB control bundle passed through.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `flush` in 1: kill the instruction in ID and the ID/EX register.
- `in_valid` in 1 / `in_ready` out 1: IF/ID handshake.
- `in_pc` in 32: byte PC of the instruction.
- `in_instr` in 32: instruction word.
- `in_ctrl` in 7: {jmp, npc_from_gpr, branch_type[2:0], extop, exsign}.
- `in_pass` in PASS_W: downstream control bundle.
- `wb_we` in 1, `wb_rw` in RA_W, `wb_wd` in XLEN: register-file write port.
- `fwd_valid` in NFWD, `fwd_rw` in NFWD*RA_W, `fwd_wd` in NFWD*XLEN: forwarding sources.
- `hz_load` in 1, `hz_rw` in RA_W: load currently in EX and its destination.
- `out_valid` out 1 / `out_ready` in 1: ID/EX handshake.
- `out_pc` out 32, `out_instr` out 32, `out_rd1`/`out_rd2` out XLEN, `out_imm` out XLEN, `out_pass` out PASS_W.
- `redirect_valid` out 1, `redirect_pc` out 32: fetch redirect.

## Operation
- Register file: `NREG` entries. Write happens on posedge when `wb_we && wb_rw!=0`. Reg 0 always reads 0.
- Operand select per rs/rt, first match wins:
  - lowest-index `fwd_valid[i]` with `fwd_rw[i]==addr`;
  - then `wb_we && wb_rw==addr`;
  - then register file.
  - Address 0 always yields 0.
- Immediate: `extop=0` means no extend (imm=0). `extop=1`: `exsign=1` sign-extends instr[15:0] to XLEN, otherwise zero-extends.
- Load-use hazard: `hz_load && hz_rw!=0 && (hz_rw==rs || hz_rw==rt)` forces `in_ready=0`.
- `in_ready = !flush && !hazard && (!out_valid || out_ready)`.
- Accept edge (`in_valid && in_ready`): load all out_* fields; out_valid<=1.
- Output handshake with no accept: out_valid<=0. A hazard therefore inserts a bubble.
- Neither accept nor handshake: hold all out_* stable.
- `flush` (highest priority): out_valid<=0 at the next edge. Data fields are don't-care.
- branch_type (id_pkg): 0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (never taken). Comparisons are signed on forwarded operands.
- Targets:
  - branch = in_pc+4+(sext(imm16)<<2);
  - jmp = {in_pc+4[31:28], instr[25:0], 2'b00};
  - npc_from_gpr = forwarded rd1[31:0].

## Timing
- Reset values: out_valid=0; out_pc, out_instr, out_rd1, out_rd2, out_imm, out_pass = 0; register file all 0.
- Latency: 1 cycle from accept to out_valid.
- `redirect_valid` is combinational. It pulses only in the accept cycle, when `in_valid && in_ready` and (jmp || npc_from_gpr || branch taken). It is never asserted during flush or stall.
- Simultaneous WB write and read of the same register: the read returns `wb_wd` (bypass), not the stale value.
- Simultaneous handshake and accept: the new instruction replaces the old one with no bubble.
- `rst` asserted mid-operation clears immediately (asynchronously). The first accept is possible on the first edge after deassertion.

## Configuration
- `ID_EARLY_BRANCH_EN` defined: branch/jump resolution in ID as above; redirect driven.
- Not defined:
  - `redirect_valid` tied 0 and `redirect_pc` tied 0;
  - no compare/target logic;
  - EX resolves control flow from out_instr/out_pass;
  - forwarding and hazard logic are unchanged.

## Structure
- `id_pkg`:
  - branch_type localparams (BR_NONE … BR_BGEZ);
  - in_ctrl field offsets;
  - extend-mode constants.
- Sub-module `id_regfile`: parametrised by XLEN/NREG; 2 read ports, 1 write port, write-to-read bypass, async active-low reset.
- Top level holds forward mux, immediate, hazard, branch and the pipeline register.

## Test plan
- Reset then write r5=0x1234 via WB. A following accept of rs=5 gives out_rd1=0x1234 one cycle later; out_valid=1.
- fwd[0] r3=0xAAAA, fwd[1] r3=0xBBBB, WB r3=0xCCCC, all in the same cycle. Result: out_rd1=0xAAAA. With fwd[0] deasserted: 0xBBBB. With both deasserted: 0xCCCC. Addressing r0 with any of these gives 0.
- hz_load=1, hz_rw=7, instr rt=7:
  - in_ready=0 for 1 cycle;
  - out_valid=0 after handshake (bubble);
  - with hazard cleared the instruction is accepted next cycle.
- out_ready=0 for 3 cycles with out_valid=1: all outputs stable and in_ready=0. Releasing allows handshake plus new accept in the same cycle.
- With `ID_EARLY_BRANCH_EN`: BEQ at pc 0x100, offset 0x0004, r1=r2=9 → redirect_valid=1, redirect_pc=0x114. With r2=8 → no redirect. JR with r31=0x400 forwarded from fwd[0] → redirect_pc=0x400.
- Flush in the same cycle as in_valid=1:
  - in_ready=0 and redirect_valid=0;
  - out_valid=0 next cycle;
  - rst pulsed mid-stall → out_valid=0 immediately.
